// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single Memory port: CPU and program loader.
// Round-robin on ties, fixed-latency access, registered ack with read data.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       we_l;
    logic       last_owner;
    logic       pick_ld;

    // Loader wins when alone, or on a tie when the CPU had the last grant.
    assign pick_ld = ld_req && (!cpu_req || !last_owner);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            we_l       <= 1'b0;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            ld_rdata   <= '0;
            cpu_ack    <= 1'b0;
            ld_ack     <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ld_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || ld_req) begin
                        owner      <= pick_ld;
                        last_owner <= pick_ld;
                        we_l       <= pick_ld ? ld_we : cpu_we;
                        mem_addr   <= pick_ld ? ld_addr : cpu_addr;
                        mem_wdata  <= pick_ld ? ld_wdata : cpu_wdata;
                        mem_read   <= pick_ld ? !ld_we : !cpu_we;
                        mem_write  <= pick_ld ? ld_we : cpu_we;
                        cnt        <= CNT_INIT;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!we_l) begin
                            if (owner) ld_rdata  <= mem_rdata;
                            else       cpu_rdata <= mem_rdata;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (owner) ld_ack  <= 1'b1;
                        else       cpu_ack <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
